imm_gen_stage: RTL
==================

# imm_gen_stage

Registered immediate-generation stage for the decode path. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes every RV32I/RV64I immediate format: R, I, S, B, U and J. It emits a sign-extended XLEN-bit immediate, a format code and an illegal flag one cycle later. A two-entry skid buffer keeps `in_ready` free of any combinational path from `out_ready`. A saturating counter tracks illegal opcodes delivered downstream.

## Interface

- `XLEN`, 32, immediate width; only 32 or 64 are legal.
- `CNT_W`, 16, width of the illegal-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction beat present.
- `in_ready`  out  1  stage can accept a beat; equals `~skid_valid`.
- `instr`  in  32  instruction word.
- `flush`  in  1  synchronous discard of all buffered beats.
- `out_valid`  out  1  `imm`, `fmt` and `illegal` are valid.
- `out_ready`  in  1  downstream accepts the beat.
- `imm`  out  XLEN  sign-extended immediate.
- `fmt`  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
- `illegal`  out  1  asserted exactly when `fmt`==7.
- `illegal_count`  out  CNT_W  saturating count of delivered illegal beats.

## Operation

- Format is selected by `opcode` = `instr[6:0]`:
  - I: 0000011, 0010011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011.
  - XLEN=64 only: 0011011 is I and 0111011 is R.
  - Every other opcode, including the two above when XLEN=32, is illegal.
- Immediate field packing before sign extension from its MSB to XLEN bits:
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}` (13 bits).
  - U: `{instr[31:12], 12'b0}` (32 bits).
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}` (21 bits).
  - R and illegal: `imm` = 0.
- Decode is combinational on `instr`. The result is captured into the buffer and never decoded on the output side.
- Buffer organisation: main register M drives the outputs; skid register K holds at most one extra beat. Data order is strictly FIFO.
- Beat accept: `in_valid && in_ready && !flush`.
  - M empty, or M draining this cycle with K empty: the beat goes to M.
  - M full and stalled: the beat goes to K.
- Beat delivery: `out_valid && out_ready`. On delivery, K (if full) moves into M in the same edge.
- `flush` clears both valid bits at the next edge and drops any beat offered that cycle. A delivery coinciding with flush still counts as delivered.
- `illegal_count` increments on each delivered beat with `fmt`==7 and saturates at all-ones. Flush does not clear it; only reset does.

## Timing

- Reset values: `out_valid`=0, `imm`=0, `fmt`=0, `illegal`=0, `illegal_count`=0, K empty, `in_ready`=1.
- Latency: a beat accepted at edge N is presented on the outputs after edge N, valid for the whole cycle N+1.
- Throughput is one beat per cycle while `out_ready`=1.
- With `out_ready` held low, two beats are absorbed (M, then K). `in_ready` falls the cycle after K fills.
- `in_ready` rises the cycle after the delivery that empties K.
- Output fields are stable while `out_valid && !out_ready`.
- Asserting `rst` mid-transfer returns to reset values immediately, with no edge required.

## Test plan

- Single beats, `out_ready`=1, XLEN=32. Each response arrives one cycle after accept:
  - `0xFFF00093` -> `imm`=0xFFFFFFFF, `fmt`=1.
  - `0xFE112E23` -> `imm`=0xFFFFFFFC, `fmt`=2.
  - `0xFE000CE3` -> `imm`=0xFFFFFFF8, `fmt`=3.
- U/J/R checks:
  - `0x123452B7` -> `imm`=0x12345000, `fmt`=4.
  - `0x0010006F` -> `imm`=0x00000800, `fmt`=5.
  - `0x002081B3` -> `imm`=0, `fmt`=0.
- Width modes with `0xFFF0009B` (addiw):
  - XLEN=64 -> `imm`=0xFFFFFFFFFFFFFFFF, `fmt`=1.
  - XLEN=32 -> `fmt`=7, `illegal`=1, `imm`=0.
- Backpressure: hold `out_ready`=0 while offering A, B, C back-to-back.
  - A and B are accepted; `in_ready`=0 after B is captured.
  - Release `out_ready`: outputs are A, B, C in order, no duplicates, and `in_ready` returns to 1.
- Flush with M and K full: `out_valid`=0 next cycle, `in_ready`=1, the beat offered in the flush cycle is lost, and `illegal_count` is unchanged.
- Counter behaviour with CNT_W=2:
  - Deliver five `0x0000007F` beats -> `illegal_count` reads 1, 2, 3, 3, 3.
  - Assert `rst` mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate decoder behind a two-entry skid buffer.
// o_in_ready depends only on skid occupancy, never on i_out_ready.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_instr,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_count
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_fmt;
    logic [31:0]     w_immRaw;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;
    logic            w_deliver;

    logic            r_mValid;
    logic [XLEN-1:0] r_mImm;
    logic [2:0]      r_mFmt;
    logic            r_kValid;
    logic [XLEN-1:0] r_kImm;
    logic [2:0]      r_kFmt;
    logic [CNT_W-1:0] r_illegalCount;

    assign w_opcode = i_instr[6:0];

    // Every format fits in 32 bits once sign-extended; widen to XLEN last.
    always_comb begin
        w_fmt    = FMT_ILL;
        w_immRaw = 32'd0;
        case (w_opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                w_fmt    = FMT_I;
                w_immRaw = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OP_STORE: begin
                w_fmt    = FMT_S;
                w_immRaw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OP_BRANCH: begin
                w_fmt    = FMT_B;
                w_immRaw = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                w_fmt    = FMT_U;
                w_immRaw = {i_instr[31:12], 12'd0};
            end
            OP_JAL: begin
                w_fmt    = FMT_J;
                w_immRaw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            end
            OP_REG: begin
                w_fmt = FMT_R;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    w_fmt    = FMT_I;
                    w_immRaw = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            OP_REG32: begin
                if (XLEN == 64) begin
                    w_fmt = FMT_R;
                end
            end
            default: begin
                w_fmt = FMT_ILL;
            end
        endcase
    end

    assign w_imm     = XLEN'($signed(w_immRaw));
    assign w_accept  = i_in_valid && o_in_ready && !i_flush;
    assign w_deliver = r_mValid && i_out_ready;

    // When M drains, K refills it first; a new beat only lands in K when M is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mValid <= 1'b0;
            r_mImm   <= '0;
            r_mFmt   <= FMT_R;
            r_kValid <= 1'b0;
            r_kImm   <= '0;
            r_kFmt   <= FMT_R;
        end else if (i_flush) begin
            r_mValid <= 1'b0;
            r_kValid <= 1'b0;
        end else if (w_deliver) begin
            if (r_kValid) begin
                r_mImm   <= r_kImm;
                r_mFmt   <= r_kFmt;
                r_kValid <= 1'b0;
            end else if (w_accept) begin
                r_mImm <= w_imm;
                r_mFmt <= w_fmt;
            end else begin
                r_mValid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_mValid) begin
                r_mValid <= 1'b1;
                r_mImm   <= w_imm;
                r_mFmt   <= w_fmt;
            end else begin
                r_kValid <= 1'b1;
                r_kImm   <= w_imm;
                r_kFmt   <= w_fmt;
            end
        end
    end

    // Counts delivered illegal beats, including one delivered during a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegalCount <= '0;
        end else if (w_deliver && (r_mFmt == FMT_ILL) &&
                     (r_illegalCount != {CNT_W{1'b1}})) begin
            r_illegalCount <= r_illegalCount + 1'b1;
        end
    end

    assign o_in_ready      = ~r_kValid;
    assign o_out_valid     = r_mValid;
    assign o_imm           = r_mImm;
    assign o_fmt           = r_mFmt;
    assign o_illegal       = (r_mFmt == FMT_ILL);
    assign o_illegal_count = r_illegalCount;

endmodule
